// File: rtl/img_proc_seq_if.sv
// Pixel sequencer bus: start/status handshake, pixel memory port and adder operands.
interface img_proc_seq_if #(
   parameter int ADDR_W = 4
);
   logic              start;
   logic [2:0]        val_add_cfg;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [2:0]        mem_rd_data;
   logic              mem_wr_en;
   logic [2:0]        mem_wr_data;
   logic [2:0]        ipu_rbg_in;
   logic [2:0]        ipu_val_add;
   logic [2:0]        ipu_rbg_out;

   modport master (
      input  start, val_add_cfg, mem_rd_data, ipu_rbg_out,
      output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
             ipu_rbg_in, ipu_val_add
   );

   modport slave (
      output start, val_add_cfg, mem_rd_data, ipu_rbg_out,
      input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
             ipu_rbg_in, ipu_val_add
   );
endinterface

// File: rtl/img_proc_seq.sv
// Read-add-write sequencer over a single-port pixel memory, 3 cycles per pixel.
// Optional IMG_SEQ_SATURATE_EN clamps overflowing sums to 3'b111 instead of wrapping.
module img_proc_seq #(
   parameter int ADDR_W  = 4,
   parameter int NUM_PIX = 16
) (
   input logic             clk,
   input logic             rst,
   img_proc_seq_if.master  bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [2:0]        offset;
   logic [2:0]        pix;
   logic [2:0]        wr_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         offset <= '0;
         pix    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  offset <= bus.val_add_cfg;
                  ptr    <= '0;
                  state  <= S_RD;
               end
            end
            S_RD:   state <= S_CAP;
            S_CAP: begin
               pix   <= bus.mem_rd_data;
               state <= S_WR;
            end
            S_WR: begin
               if (ptr == LAST_PIX) begin
                  state <= S_DONE;
               end else begin
                  ptr   <= ptr + ADDR_W'(1);
                  state <= S_RD;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef IMG_SEQ_SATURATE_EN
   // A 3-bit sum smaller than its pixel operand means the adder wrapped.
   assign wr_val = (bus.ipu_rbg_out < pix) ? 3'b111 : bus.ipu_rbg_out;
`else
   assign wr_val = bus.ipu_rbg_out;
`endif

   // All strobes and the address are decoded from the state register only.
   always_comb begin
      bus.busy        = (state == S_RD) || (state == S_CAP) ||
                        (state == S_WR) || (state == S_DONE);
      bus.done        = (state == S_DONE);
      bus.mem_rd_en   = (state == S_RD);
      bus.mem_wr_en   = (state == S_WR);
      bus.mem_addr    = ((state == S_RD) || (state == S_WR)) ? ptr : '0;
      bus.mem_wr_data = (state == S_WR) ? wr_val : '0;
      bus.ipu_rbg_in  = pix;
      bus.ipu_val_add = offset;
   end
endmodule

// File: tb/tb_img_proc_seq.sv
// Self-checking bench for img_proc_seq: behavioural pixel memory, adder and reference model.
module tb_img_proc_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   img_proc_seq_if #(.ADDR_W(4)) ifa ();
   img_proc_seq_if #(.ADDR_W(2)) ifb ();

   img_proc_seq #(.ADDR_W(4), .NUM_PIX(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
   img_proc_seq #(.ADDR_W(2), .NUM_PIX(1))  dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

   assign ifa.ipu_rbg_out = ifa.ipu_rbg_in + ifa.ipu_val_add;
   assign ifb.ipu_rbg_out = ifb.ipu_rbg_in + ifb.ipu_val_add;

   logic [2:0] mem_a [16];
   logic [2:0] exp_a [16];
   logic [2:0] mem_b [4];
   logic [2:0] rd_a = '0;
   logic [2:0] rd_b = '0;
   int wr_cnt_a = 0, wr_cnt_b = 0, rd_cnt_b = 0, done_cnt_a = 0;
   logic done_prev_a = 1'b0, done_prev_b = 1'b0;

   assign ifa.mem_rd_data = rd_a;
   assign ifb.mem_rd_data = rd_b;

   always @(posedge clk) begin
      if (ifa.mem_rd_en) rd_a <= mem_a[ifa.mem_addr];
      if (ifa.mem_wr_en) begin
         mem_a[ifa.mem_addr] = ifa.mem_wr_data;
         wr_cnt_a = wr_cnt_a + 1;
      end
      if (ifb.mem_rd_en) begin
         rd_b <= mem_b[ifb.mem_addr];
         rd_cnt_b = rd_cnt_b + 1;
      end
      if (ifb.mem_wr_en) begin
         mem_b[ifb.mem_addr] = ifb.mem_wr_data;
         wr_cnt_b = wr_cnt_b + 1;
      end
   end

   // Cycle-by-cycle protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      checks = checks + 4;
      if (ifa.mem_rd_en && ifa.mem_wr_en) begin
         errors = errors + 1;
         $display("FAIL strobe_excl_a rd=%0b wr=%0b required not both 1", ifa.mem_rd_en, ifa.mem_wr_en);
      end
      if (ifb.mem_rd_en && ifb.mem_wr_en) begin
         errors = errors + 1;
         $display("FAIL strobe_excl_b rd=%0b wr=%0b required not both 1", ifb.mem_rd_en, ifb.mem_wr_en);
      end
      if (ifa.done && done_prev_a) begin
         errors = errors + 1;
         $display("FAIL done_width_a done high 2 cycles, required 1");
      end
      if (ifb.busy && (ifb.mem_addr >= 2'd1)) begin
         errors = errors + 1;
         $display("FAIL addr_range_b addr=%0d required <1 while busy", ifb.mem_addr);
      end
      if (ifa.done) done_cnt_a = done_cnt_a + 1;
      done_prev_a = ifa.done;
      done_prev_b = ifb.done;
   end

   function automatic logic [2:0] add_px(input logic [2:0] p, input logic [2:0] o);
      int s;
      s = int'(p) + int'(o);
`ifdef IMG_SEQ_SATURATE_EN
      if (s > 7) return 3'd7;
`endif
      return 3'(s % 8);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a pass on DUT A; returns in the done cycle or on timeout.
   task automatic pass_a(input logic [2:0] off, output int lat, output int busy_n);
      ifa.val_add_cfg = off;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      ifa.val_add_cfg = 3'($urandom);
      lat = 1;
      busy_n = 0;
      while (1) begin
         if (ifa.busy) busy_n++;
         if (ifa.done || lat > 200) break;
         tick();
         lat++;
      end
   endtask

   task automatic load_rand_a();
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 3'($urandom);
         exp_a[i] = mem_a[i];
      end
   endtask

   task automatic test_reset();
      logic [18:0] va;
      logic [16:0] vb;
      rst = 1'b1;
      tick();
      tick();
      va = {ifa.busy, ifa.done, ifa.mem_addr, ifa.mem_rd_en, ifa.mem_wr_en,
            ifa.mem_wr_data, ifa.ipu_rbg_in, ifa.ipu_val_add};
      vb = {ifb.busy, ifb.done, ifb.mem_addr, ifb.mem_rd_en, ifb.mem_wr_en,
            ifb.mem_wr_data, ifb.ipu_rbg_in, ifb.ipu_val_add};
      checks += 2;
      if (va !== '0) begin errors++; $display("FAIL reset_a outputs=%h required 0", va); end
      if (vb !== '0) begin errors++; $display("FAIL reset_b outputs=%h required 0", vb); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      int lat, busy_n, bad;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 3'(i % 8);
         exp_a[i] = 3'((i % 8 + 1) % 8);
      end
      pass_a(3'd1, lat, busy_n);
      checks += 2;
      if (lat !== 49) begin errors++; $display("FAIL wrap_latency got %0d required 49", lat); end
      if (busy_n !== 49) begin errors++; $display("FAIL wrap_busy got %0d required 49", busy_n); end
      tick();
      checks++;
      if (ifa.busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_after got %0b required 0", ifa.busy); end
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_a[i] !== exp_a[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL wrap_mem %0d pixels wrong, required 0 (mem[7]=%0d want %0d)", bad, mem_a[7], exp_a[7]); end
   endtask

   task automatic test_random_passes();
      int lat, busy_n, bad;
      logic [2:0] off;
      for (int p = 0; p < 4; p++) begin
         load_rand_a();
         off = 3'($urandom);
         for (int i = 0; i < 16; i++) exp_a[i] = add_px(exp_a[i], off);
         pass_a(off, lat, busy_n);
         tick();
         bad = 0;
         for (int i = 0; i < 16; i++) if (mem_a[i] !== exp_a[i]) bad++;
         checks += 2;
         if (lat !== 49) begin errors++; $display("FAIL rand_latency pass %0d got %0d required 49", p, lat); end
         if (bad != 0) begin errors++; $display("FAIL rand_mem pass %0d off=%0d bad=%0d required 0", p, off, bad); end
      end
   endtask

   task automatic test_start_while_busy();
      int d0, bad;
      load_rand_a();
      for (int i = 0; i < 16; i++) exp_a[i] = add_px(exp_a[i], 3'd3);
      d0 = done_cnt_a;
      ifa.val_add_cfg = 3'd3;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      ifa.val_add_cfg = 3'd5;
      repeat (10) tick();
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      repeat (60) tick();
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_a[i] !== exp_a[i]) bad++;
      checks += 3;
      if (done_cnt_a - d0 != 1) begin errors++; $display("FAIL busy_start_dones got %0d required 1", done_cnt_a - d0); end
      if (ifa.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle busy=%0b required 0", ifa.busy); end
      if (bad != 0) begin errors++; $display("FAIL busy_start_mem bad=%0d required 0", bad); end
   endtask

   task automatic test_saturate();
      int lat, busy_n, bad;
      logic [2:0] want0;
`ifdef IMG_SEQ_SATURATE_EN
      want0 = 3'd7;
`else
      want0 = 3'd1;
`endif
      load_rand_a();
      mem_a[0] = 3'd6; exp_a[0] = 3'd6;
      mem_a[1] = 3'd2; exp_a[1] = 3'd2;
      for (int i = 0; i < 16; i++) exp_a[i] = add_px(exp_a[i], 3'd3);
      pass_a(3'd3, lat, busy_n);
      tick();
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_a[i] !== exp_a[i]) bad++;
      checks += 3;
      if (mem_a[0] !== want0) begin errors++; $display("FAIL sat_6p3 got %0d required %0d", mem_a[0], want0); end
      if (mem_a[1] !== 3'd5) begin errors++; $display("FAIL sat_2p3 got %0d required 5", mem_a[1]); end
      if (bad != 0) begin errors++; $display("FAIL sat_mem bad=%0d required 0", bad); end
   endtask

   task automatic test_single_pixel();
      int lat, r0, w0, addr_bad;
      logic [2:0] orig [4];
      logic [2:0] off;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 4; i++) begin mem_b[i] = 3'($urandom); orig[i] = mem_b[i]; end
         off = (p == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         r0 = rd_cnt_b; w0 = wr_cnt_b; addr_bad = 0;
         ifb.val_add_cfg = off;
         ifb.start = 1'b1;
         tick();
         ifb.start = 1'b0;
         lat = 1;
         if (!(ifb.mem_rd_en === 1'b1 && ifb.mem_addr === 2'd0)) addr_bad = 1;
         while (!ifb.done && lat <= 20) begin tick(); lat++; end
         tick();
         checks += 5;
         if (lat !== 4) begin errors++; $display("FAIL single_latency pass %0d got %0d required 4", p, lat); end
         if (addr_bad != 0) begin errors++; $display("FAIL single_first_read pass %0d rd/addr wrong, required rd=1 addr=0", p); end
         if (rd_cnt_b - r0 != 1 || wr_cnt_b - w0 != 1) begin
            errors++; $display("FAIL single_access pass %0d rd=%0d wr=%0d required 1/1", p, rd_cnt_b - r0, wr_cnt_b - w0);
         end
         if (mem_b[0] !== add_px(orig[0], off)) begin
            errors++; $display("FAIL single_value pass %0d got %0d required %0d", p, mem_b[0], add_px(orig[0], off));
         end
         if ({mem_b[1], mem_b[2], mem_b[3]} !== {orig[1], orig[2], orig[3]}) begin
            errors++; $display("FAIL single_untouched pass %0d other pixels modified", p);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, busy_n, bad;
      logic [2:0] o1, o2;
      load_rand_a();
      o1 = 3'($urandom);
      o2 = 3'($urandom);
      for (int i = 0; i < 16; i++) exp_a[i] = add_px(add_px(exp_a[i], o1), o2);
      pass_a(o1, lat, busy_n);
      // Pulse in the DONE cycle must be dropped.
      ifa.val_add_cfg = 3'($urandom);
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      checks++;
      if (ifa.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start busy=%0b required 0", ifa.busy); end
      pass_a(o2, lat, busy_n);
      tick();
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_a[i] !== exp_a[i]) bad++;
      checks += 2;
      if (lat !== 49) begin errors++; $display("FAIL b2b_latency got %0d required 49", lat); end
      if (bad != 0) begin errors++; $display("FAIL b2b_mem bad=%0d required 0", bad); end
   endtask

   task automatic test_reset_midpass();
      int k, w0, d0, bad, nwr;
      logic [17:0] va;
      load_rand_a();
      do k = $urandom_range(4, 47); while (k % 3 == 0);
      nwr = k / 3;
      for (int i = 0; i < nwr; i++) exp_a[i] = add_px(exp_a[i], 3'd6);
      w0 = wr_cnt_a; d0 = done_cnt_a;
      ifa.val_add_cfg = 3'd6;
      ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
      repeat (k - 1) tick();
      rst = 1'b1;
      tick();
      va = {ifa.busy, ifa.done, ifa.mem_addr, ifa.mem_rd_en, ifa.mem_wr_en,
            ifa.mem_wr_data, ifa.ipu_rbg_in, ifa.ipu_val_add};
      checks++;
      if (va !== '0) begin errors++; $display("FAIL midrst_outputs k=%0d got %h required 0", k, va); end
      tick();
      rst = 1'b0;
      repeat (60) tick();
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_a[i] !== exp_a[i]) bad++;
      checks += 4;
      if (wr_cnt_a - w0 != nwr) begin errors++; $display("FAIL midrst_writes k=%0d got %0d required %0d", k, wr_cnt_a - w0, nwr); end
      if (done_cnt_a != d0) begin errors++; $display("FAIL midrst_done got %0d pulses required 0", done_cnt_a - d0); end
      if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle busy=%0b required 0", ifa.busy); end
      if (bad != 0) begin errors++; $display("FAIL midrst_mem k=%0d bad=%0d required 0", k, bad); end
   endtask

   initial begin
      ifa.start = 1'b0; ifa.val_add_cfg = '0;
      ifb.start = 1'b0; ifb.val_add_cfg = '0;
      for (int i = 0; i < 16; i++) begin mem_a[i] = '0; exp_a[i] = '0; end
      for (int i = 0; i < 4; i++) mem_b[i] = '0;
      test_reset();
      test_wrap();
      test_random_passes();
      test_start_while_busy();
      test_saturate();
      test_single_pixel();
      test_back_to_back();
      test_reset_midpass();
      test_reset_midpass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
